// File: rtl/servo_en_seq.sv
// -----------------------------------------------------------------------------
// servo_en_seq
// Re-armable power-up sequencer for temperature-servo enable lines.
// After an arm event all channel enables are held low for DLY_INIT cycles,
// then channels are released one at a time, STAGGER cycles apart, in
// ascending index order. A released channel simply follows its software
// enable. The sequence can be restarted (arm) or cancelled (abort) at any time.
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   arm      - synchronous pulse, starts or restarts the sequence
//   abort    - synchronous level, forces all outputs off and holds IDLE
//   en_in    - requested channel enables [NCH]
//   en_out   - gated channel enables, registered [NCH]
//   rel_mask - set of released channels [NCH]
//   busy     - high while in WAIT or STAG
//   state    - current state: 0 IDLE, 1 WAIT, 2 STAG, 3 RUN
// -----------------------------------------------------------------------------
module servo_en_seq #(
   parameter int NCH      = 10,
   parameter int CNT_W    = 32,
   parameter int DLY_INIT = 1_000_000,
   parameter int STAGGER  = 100_000,
   parameter bit AUTO_ARM = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             abort,
   input  logic [NCH-1:0]   en_in,
   output logic [NCH-1:0]   en_out,
   output logic [NCH-1:0]   rel_mask,
   output logic             busy,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_STAG = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   localparam int             IDX_W    = $clog2(NCH + 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_INIT - 1);
   localparam logic [CNT_W-1:0] STG_LAST = CNT_W'((STAGGER > 0) ? STAGGER - 1 : 0);
   localparam logic [NCH-1:0]   ALL_ON   = '1;
   // With a zero stagger, or a single channel, every channel goes at once.
   localparam bit               REL_ALL  = (STAGGER == 0) || (NCH == 1);

   // Parameter sanity, caught at elaboration.
   if (NCH < 1 || NCH > 32) begin : g_bad_nch
      $error("servo_en_seq: NCH must be in 1..32");
   end
   if (DLY_INIT < 1 || STAGGER < 0) begin : g_bad_dly
      $error("servo_en_seq: DLY_INIT must be >= 1 and STAGGER >= 0");
   end
   if ((CNT_W < 32) && (((DLY_INIT >> CNT_W) != 0) || ((STAGGER >> CNT_W) != 0))) begin : g_bad_w
      $error("servo_en_seq: DLY_INIT/STAGGER do not fit in CNT_W bits");
   end

   state_t             state_q, state_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [IDX_W-1:0]   idx_q, idx_nxt;
   logic [NCH-1:0]     mask_nxt;
   logic               auto_pend_q;
   logic               arm_evt;

   // The automatic arm is a one-shot: it only exists on the first edge after
   // reset release and is consumed (or cancelled by abort) on that edge.
   assign arm_evt = arm | auto_pend_q;

   // NOTE: every signal gets a default before the case statement, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      idx_nxt   = idx_q;
      mask_nxt  = rel_mask;

      if (abort) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
         mask_nxt  = '0;
      end else if (arm_evt) begin
         state_nxt = S_WAIT;
         cnt_nxt   = '0;
         idx_nxt   = '0;
         mask_nxt  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cnt_nxt  = '0;
               mask_nxt = '0;
            end
            S_WAIT: begin
               if (cnt_q == DLY_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = (NCH == 1) ? S_RUN : S_STAG;
                  if (REL_ALL) begin
                     mask_nxt = ALL_ON;
                     idx_nxt  = IDX_W'(NCH);
                  end else begin
                     mask_nxt[0] = 1'b1;
                     idx_nxt     = IDX_W'(1);
                  end
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            S_STAG: begin
               if (&rel_mask) begin
                  state_nxt = S_RUN;
                  cnt_nxt   = '0;
               end else if (cnt_q == STG_LAST) begin
                  cnt_nxt = '0;
                  idx_nxt = idx_q + IDX_W'(1);
                  for (int i = 0; i < NCH; i++) begin
                     if (idx_q == IDX_W'(i)) mask_nxt[i] = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               cnt_nxt  = '0;
               mask_nxt = ALL_ON;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // NOTE: state is written with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         rel_mask    <= '0;
         en_out      <= '0;
         busy        <= 1'b0;
         auto_pend_q <= AUTO_ARM;
      end else begin
         state_q     <= state_nxt;
         cnt_q       <= cnt_nxt;
         idx_q       <= idx_nxt;
         rel_mask    <= mask_nxt;
         // Gate with the mask being loaded on this edge so a channel is seen
         // high on the same edge it is released, and an arm/abort blanks the
         // outputs on that very edge.
         en_out      <= en_in & mask_nxt;
         busy        <= (state_nxt == S_WAIT) || (state_nxt == S_STAG);
         auto_pend_q <= 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_servo_en_seq.sv
// -----------------------------------------------------------------------------
// tb_servo_en_seq
// Three sequencers (NCH=4, DLY_INIT=10) share clock, reset and en_in:
//   0: AUTO_ARM=1, STAGGER=3
//   1: AUTO_ARM=0, STAGGER=3
//   2: AUTO_ARM=1, STAGGER=0
// A reference model tracks only the edge of the last arm per instance and
// derives every output from elapsed edges with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_servo_en_seq;

   localparam int N = 4;
   localparam int D = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   arm;
   logic [2:0]   abort;
   logic [N-1:0] en_in;

   logic [N-1:0] en_out_o   [3];
   logic [N-1:0] rel_mask_o [3];
   logic [2:0]   busy_o;
   logic [1:0]   state_o    [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   int           arm_edge  [3];
   bit           pend      [3];
   logic [N-1:0] exp_en    [3];
   logic [N-1:0] exp_mask  [3];
   logic [1:0]   exp_state [3];
   logic         exp_busy  [3];

   always #5 clk = ~clk;

   servo_en_seq #(.NCH(N), .CNT_W(8), .DLY_INIT(D), .STAGGER(3), .AUTO_ARM(1'b1)) u_auto (
      .clk(clk), .rst_n(rst_n), .arm(arm[0]), .abort(abort[0]), .en_in(en_in),
      .en_out(en_out_o[0]), .rel_mask(rel_mask_o[0]), .busy(busy_o[0]), .state(state_o[0]));

   servo_en_seq #(.NCH(N), .CNT_W(8), .DLY_INIT(D), .STAGGER(3), .AUTO_ARM(1'b0)) u_manual (
      .clk(clk), .rst_n(rst_n), .arm(arm[1]), .abort(abort[1]), .en_in(en_in),
      .en_out(en_out_o[1]), .rel_mask(rel_mask_o[1]), .busy(busy_o[1]), .state(state_o[1]));

   servo_en_seq #(.NCH(N), .CNT_W(32), .DLY_INIT(D), .STAGGER(0), .AUTO_ARM(1'b1)) u_nostag (
      .clk(clk), .rst_n(rst_n), .arm(arm[2]), .abort(abort[2]), .en_in(en_in),
      .en_out(en_out_o[2]), .rel_mask(rel_mask_o[2]), .busy(busy_o[2]), .state(state_o[2]));

   function automatic int stg_of(int k);
      return (k == 2) ? 0 : 3;
   endfunction

   function automatic bit auto_of(int k);
      return (k != 1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         arm_edge[k]  = -1;
         pend[k]      = auto_of(k);
         exp_en[k]    = '0;
         exp_mask[k]  = '0;
         exp_state[k] = 2'd0;
         exp_busy[k]  = 1'b0;
      end
   endtask

   // Apply the inputs sampled at edge number cyc.
   task automatic model_edge();
      int d;
      logic [N-1:0] m;
      logic [1:0]   st;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 3; k++) begin
         if (abort[k]) begin
            arm_edge[k] = -1;
            pend[k]     = 1'b0;
         end else if (arm[k] || pend[k]) begin
            arm_edge[k] = cyc;
            pend[k]     = 1'b0;
         end
         m  = '0;
         st = 2'd0;
         if (arm_edge[k] >= 0) begin
            d = cyc - arm_edge[k];
            // channel ch is released DLY_INIT + ch*STAGGER edges after arm
            for (int ch = 0; ch < N; ch++)
               if (d >= D + ch * stg_of(k)) m[ch] = 1'b1;
            if (d < D)                          st = 2'd1;
            else if (d > D + (N - 1) * stg_of(k)) st = 2'd3;
            else                                st = 2'd2;
         end
         exp_mask[k]  = m;
         exp_en[k]    = en_in & m;
         exp_state[k] = st;
         exp_busy[k]  = (st == 2'd1) || (st == 2'd2);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("en_out[%0d]@%0d", k, cyc - 1),   32'(en_out_o[k]),   32'(exp_en[k]));
         check($sformatf("rel_mask[%0d]@%0d", k, cyc - 1), 32'(rel_mask_o[k]), 32'(exp_mask[k]));
         check($sformatf("state[%0d]@%0d", k, cyc - 1),    32'(state_o[k]),    32'(exp_state[k]));
         check($sformatf("busy[%0d]@%0d", k, cyc - 1),     32'(busy_o[k]),     32'(exp_busy[k]));
      end
   endtask

   // One clock edge: update the model with the inputs the DUT sampled,
   // then compare 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      check_all();
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      arm   = '0;
      abort = '0;
      en_in = '1;
      model_reset();

      // reset state
      repeat (2) tick();

      // release reset; the next edge is edge 0 and auto-arms instances 0 and 2
      rst_n = 1'b1;
      cyc   = 0;
      run_to(31);

      // in RUN: drop en_in[2] after edge 30, restore after edge 40
      en_in = 4'b1011;
      run_to(41);
      en_in = 4'b1111;

      // manual instance stays idle until armed at edge 50
      run_to(50);
      arm[1] = 1'b1;
      tick();
      arm[1] = 1'b0;

      // re-arm instance 0 at 70, and again mid-STAG at 84 (mask 0011)
      run_to(70);
      arm[0] = 1'b1;
      tick();
      arm[0] = 1'b0;
      run_to(84);
      arm[0] = 1'b1;
      tick();
      arm[0] = 1'b0;
      run_to(120);

      // arm at 120, then arm+abort together in STAG at 132
      arm[0] = 1'b1;
      tick();
      arm[0] = 1'b0;
      run_to(132);
      arm[0]   = 1'b1;
      abort[0] = 1'b1;
      tick();
      arm[0] = 1'b0;
      tick();
      arm[0] = 1'b1;   // arm while abort still high is ignored
      tick();
      arm[0] = 1'b0;
      tick();
      abort[0] = 1'b0;
      repeat (20) tick();   // no automatic re-arm after abort
      arm[0] = 1'b1;
      tick();
      arm[0] = 1'b0;
      repeat (25) tick();

      // randomized phase
      repeat (400) begin
         en_in = N'($urandom);
         for (int k = 0; k < 3; k++) begin
            arm[k]   = ($urandom_range(0, 39) == 0);
            abort[k] = ($urandom_range(0, 59) == 0);
         end
         tick();
      end
      arm   = '0;
      abort = '0;
      en_in = '1;
      repeat (30) tick();

      // asynchronous reset in the middle of WAIT
      arm = 3'b111;
      tick();
      arm = '0;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (30) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
